// File: rtl/encoder_scheduler_pkg.sv
// Shared constants and types for the encoder scheduler slice.
// Optional feature macro: ENC_SCHED_TIMEOUT_EN (RUN-state watchdog).
package encoder_scheduler_pkg;

    localparam int unsigned BYTE_ADDR_W     = 12;
    localparam int unsigned ENC_BYTE_ADDR_W = 10;
    localparam int unsigned ENC_POLY_ADDR_W = 9;
    localparam int unsigned BANK_W          = 2;
    localparam int unsigned POLY_ADDR_W     = BANK_W + ENC_POLY_ADDR_W;
    localparam int unsigned BYTE_DATA_W     = 8;
    localparam int unsigned TIMEOUT_W       = 12;
    localparam int unsigned TIMEOUT_LIMIT   = 4095;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_ACK   = 2'd3
    } sched_state_t;

    // Byte RAM address: base plus zero-extended encoder offset, wrapping at 4096.
    function automatic logic [BYTE_ADDR_W-1:0] wrap_addr(
        input logic [BYTE_ADDR_W-1:0]     base,
        input logic [ENC_BYTE_ADDR_W-1:0] offset
    );
        return base + BYTE_ADDR_W'(offset);
    endfunction

endpackage

// File: rtl/encoder_scheduler_if.sv
// Encoder-side and memory-side bus of the encoder scheduler.
// master: the scheduler; slave: the encoder core plus RAM side.
interface encoder_scheduler_if;
    import encoder_scheduler_pkg::*;

    logic                       enc_start;
    logic                       enc_done;
    logic                       enc_byte_we;
    logic [ENC_BYTE_ADDR_W-1:0] enc_byte_addr;
    logic [BYTE_DATA_W-1:0]     enc_byte_di;
    logic [ENC_POLY_ADDR_W-1:0] enc_poly_addra;
    logic                       byte_we;
    logic [BYTE_ADDR_W-1:0]     byte_addr;
    logic [BYTE_DATA_W-1:0]     byte_di;
    logic [POLY_ADDR_W-1:0]     poly_addra;

    modport master (
        output enc_start, byte_we, byte_addr, byte_di, poly_addra,
        input  enc_done, enc_byte_we, enc_byte_addr, enc_byte_di, enc_poly_addra
    );

    modport slave (
        input  enc_start, byte_we, byte_addr, byte_di, poly_addra,
        output enc_done, enc_byte_we, enc_byte_addr, enc_byte_di, enc_poly_addra
    );

endinterface

// File: rtl/encoder_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter with a registered priority pointer.
// ptr == 0 favours req[0]; after a grant the pointer favours the other side.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic ptr;

    // Pick a winner: pointer decides only when both sides request.
    always_comb begin
        gnt_valid = |req;
        if (req[0] && req[1]) gnt_idx = ptr;
        else                  gnt_idx = req[1];
    end

    // Move priority away from whoever was just granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       ptr <= 1'b0;
        else if (accept && gnt_valid)   ptr <= ~gnt_idx;
    end

endmodule

// File: rtl/encoder_scheduler.sv
// Encoder scheduler: arbitrates two encode requesters onto one encoder core,
// relocates its poly/byte RAM accesses and returns a one-cycle ack.
// Optional feature macro: ENC_SCHED_TIMEOUT_EN adds a RUN watchdog and timeout port.
module encoder_scheduler
    import encoder_scheduler_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0,
    input  logic                   req1,
    input  logic [BANK_W-1:0]      req0_bank,
    input  logic [BANK_W-1:0]      req1_bank,
    input  logic [BYTE_ADDR_W-1:0] req0_base,
    input  logic [BYTE_ADDR_W-1:0] req1_base,
    output logic                   ack0,
    output logic                   ack1,
    output logic                   busy,
`ifdef ENC_SCHED_TIMEOUT_EN
    output logic                   timeout,
`endif
    encoder_scheduler_if.master    bus
);

    sched_state_t           state, state_nxt;
    logic                   gnt_valid, gnt_idx, grant;
    logic                   owner_q;
    logic [BANK_W-1:0]      bank_q;
    logic [BYTE_ADDR_W-1:0] base_q;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({req1, req0}),
        .accept    (state == ST_IDLE),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign grant = (state == ST_IDLE) && gnt_valid;

`ifdef ENC_SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic                 to_q;
    logic                 wd_expired;

    assign wd_expired = (wd_cnt == TIMEOUT_W'(TIMEOUT_LIMIT));

    // Watchdog: wd_cnt holds the index (from 1) of the current RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            if (state == ST_START)
                wd_cnt <= TIMEOUT_W'(1);
            else if (state == ST_RUN && !wd_expired)
                wd_cnt <= wd_cnt + 1'b1;
            if (state == ST_RUN)
                to_q <= wd_expired && !bus.enc_done;
        end
    end

    assign timeout = (state == ST_ACK) && to_q;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; requests only matter in IDLE, done only in RUN.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (gnt_valid) state_nxt = ST_START;
            ST_START: state_nxt = ST_RUN;
            ST_RUN: begin
                if (bus.enc_done) state_nxt = ST_ACK;
`ifdef ENC_SCHED_TIMEOUT_EN
                else if (wd_expired) state_nxt = ST_ACK;
`endif
            end
            ST_ACK:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs plus RUN-gated byte write enable.
    always_comb begin
        bus.enc_start = (state == ST_START);
        busy          = (state != ST_IDLE);
        ack0          = (state == ST_ACK) && !owner_q;
        ack1          = (state == ST_ACK) &&  owner_q;
        bus.byte_we   = bus.enc_byte_we && (state == ST_RUN);
    end

    // Capture owner, bank and base of the granted requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= 1'b0;
            bank_q  <= '0;
            base_q  <= '0;
        end else if (grant) begin
            owner_q <= gnt_idx;
            bank_q  <= gnt_idx ? req1_bank : req0_bank;
            base_q  <= gnt_idx ? req1_base : req0_base;
        end
    end

    // Address relocation toward the shared RAMs.
    always_comb begin
        bus.poly_addra = {bank_q, bus.enc_poly_addra};
        bus.byte_addr  = wrap_addr(base_q, bus.enc_byte_addr);
        bus.byte_di    = bus.enc_byte_di;
    end

endmodule

// File: tb/tb_encoder_scheduler.sv
// Directed self-checking bench for encoder_scheduler.
// Optional feature macro: ENC_SCHED_TIMEOUT_EN selects the watchdog scenario.
module tb_encoder_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [1:0]  req0_bank = '0, req1_bank = '0;
    logic [11:0] req0_base = '0, req1_base = '0;
    logic        ack0, ack1, busy;
`ifdef ENC_SCHED_TIMEOUT_EN
    logic        timeout;
`endif

    int tests  = 0;
    int failed = 0;

    encoder_scheduler_if bus ();

    encoder_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .req0_bank (req0_bank),
        .req1_bank (req1_bank),
        .req0_base (req0_base),
        .req1_base (req1_base),
        .ack0      (ack0),
        .ack1      (ack1),
        .busy      (busy),
`ifdef ENC_SCHED_TIMEOUT_EN
        .timeout   (timeout),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // One granted transaction: the request must already be driven.
    task automatic serve(input int who, input logic [1:0] bank, input logic [11:0] base,
                         input int nwrites, input string tag);
        logic [11:0] exp_addr;
        logic [10:0] exp_poly;
        logic [7:0]  exp_di;
        int          errs = 0;
        @(posedge clk); #2;
        tests++;
        if (bus.enc_start !== 1'b1 || busy !== 1'b1) begin
            failed++;
            $display("FAIL %s_start: enc_start=%b busy=%b, expected 1 1", tag, bus.enc_start, busy);
        end
        @(posedge clk); #2;
        tests++;
        if (bus.enc_start !== 1'b0 || busy !== 1'b1) begin
            failed++;
            $display("FAIL %s_start_pulse: enc_start=%b busy=%b, expected 0 1", tag, bus.enc_start, busy);
        end
        for (int i = 0; i < nwrites; i++) begin
            bus.enc_byte_we    = 1'b1;
            bus.enc_byte_addr  = 10'(i);
            bus.enc_byte_di    = 8'(i * 7 + 3);
            bus.enc_poly_addra = 9'(i % 128);
            #1;
            exp_addr = 12'(int'(base) + i);
            exp_poly = {bank, 9'(i % 128)};
            exp_di   = 8'(i * 7 + 3);
            tests++;
            if (bus.byte_we !== 1'b1 || bus.byte_addr !== exp_addr ||
                bus.poly_addra !== exp_poly || bus.byte_di !== exp_di) begin
                failed++;
                if (errs < 8)
                    $display("FAIL %s_write[%0d]: we=%b addr=%h poly=%h di=%h, expected 1 %h %h %h",
                             tag, i, bus.byte_we, bus.byte_addr, bus.poly_addra, bus.byte_di,
                             exp_addr, exp_poly, exp_di);
                errs++;
            end
            @(posedge clk); #2;
        end
        bus.enc_byte_we = 1'b0;
        bus.enc_done    = 1'b1;
        #1;
        tests++;
        if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b1) begin
            failed++;
            $display("FAIL %s_run_hold: ack0=%b ack1=%b busy=%b, expected 0 0 1", tag, ack0, ack1, busy);
        end
        @(posedge clk); #2;
        bus.enc_done = 1'b0;
        tests++;
        if (ack0 !== (who == 0) || ack1 !== (who == 1) || busy !== 1'b1) begin
            failed++;
            $display("FAIL %s_ack: ack0=%b ack1=%b busy=%b, expected %b %b 1",
                     tag, ack0, ack1, busy, who == 0, who == 1);
        end
        if (who == 0) req0 = 1'b0;
        else          req1 = 1'b0;
        @(posedge clk); #2;
        tests++;
        if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL %s_idle: ack0=%b ack1=%b busy=%b, expected 0 0 0", tag, ack0, ack1, busy);
        end
    endtask

    task automatic test_reset();
        bus.enc_done       = 1'b0;
        bus.enc_byte_we    = 1'b1;
        bus.enc_byte_addr  = 10'h155;
        bus.enc_byte_di    = 8'h00;
        bus.enc_poly_addra = 9'h0AB;
        #2;
        tests++;
        if (busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 || bus.enc_start !== 1'b0 ||
            bus.byte_we !== 1'b0 || bus.byte_addr !== 12'h155 || bus.poly_addra !== 11'h0AB) begin
            failed++;
            $display("FAIL reset_values: busy=%b ack=%b%b start=%b we=%b addr=%h poly=%h, expected 0 00 0 0 155 0ab",
                     busy, ack1, ack0, bus.enc_start, bus.byte_we, bus.byte_addr, bus.poly_addra);
        end
        bus.enc_byte_we = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_arbitration();
        req0 = 1'b1; req0_bank = 2'd1; req0_base = 12'h010;
        req1 = 1'b1; req1_bank = 2'd3; req1_base = 12'h200;
        serve(0, 2'd1, 12'h010, 4, "arb_first");
        serve(1, 2'd3, 12'h200, 4, "arb_second");
        req0 = 1'b1; req1 = 1'b1;
        serve(0, 2'd1, 12'h010, 3, "arb_third");
        serve(1, 2'd3, 12'h200, 3, "arb_fourth");
    endtask

    task automatic test_single();
        req0 = 1'b1; req0_bank = 2'd2; req0_base = 12'h100;
        serve(0, 2'd2, 12'h100, 896, "single");
    endtask

    task automatic test_wrap();
        req0 = 1'b1; req0_bank = 2'd0; req0_base = 12'hF00;
        serve(0, 2'd0, 12'hF00, 896, "wrap");
    endtask

    task automatic test_idle_inject();
        bus.enc_byte_we   = 1'b1;
        bus.enc_byte_addr = 10'h3FF;
        bus.enc_done      = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (bus.byte_we !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin
                failed++;
                $display("FAIL idle_inject[%0d]: we=%b ack=%b%b busy=%b, expected 0 00 0",
                         c, bus.byte_we, ack1, ack0, busy);
            end
            @(posedge clk); #2;
        end
        bus.enc_byte_we = 1'b0;
        bus.enc_done    = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_reset_mid_run();
        req0 = 1'b1; req0_bank = 2'd2; req0_base = 12'h100;
        @(posedge clk); #2;
        @(posedge clk); #2;
        for (int i = 0; i < 300; i++) begin
            bus.enc_byte_we    = 1'b1;
            bus.enc_byte_addr  = 10'(i);
            bus.enc_poly_addra = 9'(i % 128);
            @(posedge clk); #2;
        end
        bus.enc_byte_addr  = 10'd300;
        bus.enc_poly_addra = 9'd44;
        #1;
        tests++;
        if (bus.byte_we !== 1'b1 || bus.byte_addr !== 12'h22C || busy !== 1'b1) begin
            failed++;
            $display("FAIL rst_pre: we=%b addr=%h busy=%b, expected 1 22c 1", bus.byte_we, bus.byte_addr, busy);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || bus.byte_we !== 1'b0 || bus.enc_start !== 1'b0 || ack0 !== 1'b0 ||
            ack1 !== 1'b0 || bus.byte_addr !== 12'd300 || bus.poly_addra !== 11'd44) begin
            failed++;
            $display("FAIL rst_immediate: busy=%b we=%b start=%b ack=%b%b addr=%h poly=%h, expected 0 0 0 00 12c 02c",
                     busy, bus.byte_we, bus.enc_start, ack1, ack0, bus.byte_addr, bus.poly_addra);
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #2;
            tests++;
            if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin
                failed++;
                $display("FAIL rst_hold[%0d]: ack=%b%b busy=%b, expected 00 0", c, ack1, ack0, busy);
            end
        end
        req0 = 1'b0;
        bus.enc_byte_we = 1'b0;
        rst = 1'b1;
        @(posedge clk); #2;
        req1 = 1'b1; req1_bank = 2'd1; req1_base = 12'h7F0;
        serve(1, 2'd1, 12'h7F0, 20, "rst_recover");
    endtask

    task automatic test_timeout();
        int  cycles = 0;
        logic stuck_ok = 1'b1;
        req0 = 1'b1; req0_bank = 2'd0; req0_base = 12'h000;
        @(posedge clk); #2;
        tests++;
        if (bus.enc_start !== 1'b1) begin
            failed++;
            $display("FAIL wd_start: enc_start=%b, expected 1", bus.enc_start);
        end
`ifdef ENC_SCHED_TIMEOUT_EN
        while (cycles < 5000) begin
            @(posedge clk); #2;
            cycles++;
            if (ack0 === 1'b1) break;
        end
        tests++;
        if (cycles != 4096 || ack0 !== 1'b1 || timeout !== 1'b1) begin
            failed++;
            $display("FAIL wd_expire: cycles=%0d ack0=%b timeout=%b, expected 4096 1 1", cycles, ack0, timeout);
        end
        req0 = 1'b0;
        @(posedge clk); #2;
        tests++;
        if (ack0 !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL wd_after: ack0=%b timeout=%b busy=%b, expected 0 0 0", ack0, timeout, busy);
        end
`else
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #2;
            cycles++;
            if (busy !== 1'b1 || ack0 !== 1'b0) stuck_ok = 1'b0;
        end
        tests++;
        if (stuck_ok !== 1'b1) begin
            failed++;
            $display("FAIL no_wd_wait: busy dropped or ack seen within %0d cycles, expected busy held", cycles);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL no_wd_reset: busy=%b, expected 0", busy);
        end
        req0 = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_single();
        test_wrap();
        test_idle_inject();
        test_reset_mid_run();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
